wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the EX/WB pipeline register in the 4-stage 8-bit processor.
- Holds the architectural register file and commits EX_WB_ALUResult to register EX_WB_Reg when EX_WB_RegWrite is set.
- Serves two read ports to the ID stage, with a write-through bypass so a writeback and a read in the same cycle need no extra stall.
- Keeps a saturating retired-write counter for debug and bring-up.

Parameters:
- DATA_W, 8, register data width; matches ALU result width.
- ADDR_W, 3, register address width; register count is 2**ADDR_W.
- R0_ZERO, 0, when 1, register 0 reads as 0 and writes to it are discarded.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- EX_WB_RegWrite  input  1  writeback enable from the EX/WB register.
- EX_WB_Reg  input  ADDR_W  writeback destination register.
- EX_WB_ALUResult  input  DATA_W  writeback data.
- ReadReg1  input  ADDR_W  ID-stage source register 1.
- ReadReg2  input  ADDR_W  ID-stage source register 2.
- ReadData1  output  DATA_W  operand 1, combinational.
- ReadData2  output  DATA_W  operand 2, combinational.
- WbCount  output  CNT_W  number of committed writes, saturating.
- WbValid  output  1  registered; high for one cycle after each committed write.

Behaviour:
- Reset:
  - Decided: one clock; reset is asynchronous and active-low (clk, rst; polarity and synchronicity fixed).
  - rst==0 immediately clears all registers to 0, WbCount to 0 and WbValid to 0, independent of clk.
  - Reset asserted mid-operation discards any write pending that edge.
  - On rst deassertion, the first posedge with EX_WB_RegWrite=1 commits normally.
- Committed write:
  - A write commits at posedge clk when rst==1, EX_WB_RegWrite==1, and not (R0_ZERO==1 and EX_WB_Reg==0).
  - On commit: regs[EX_WB_Reg] <= EX_WB_ALUResult, with latency of 1 edge to storage.
  - EX_WB_RegWrite==0 leaves storage unchanged, whatever EX_WB_Reg and EX_WB_ALUResult hold.
- Read ports (combinational, evaluated per port independently):
  - If R0_ZERO==1 and ReadRegN==0, output 0.
  - Else if EX_WB_RegWrite==1 and EX_WB_Reg==ReadRegN, output EX_WB_ALUResult (bypass, same cycle).
  - Else output regs[ReadRegN].
  - Both ports may address the same register; both get identical data, including through the bypass.
  - When EX_WB_Reg==0 and R0_ZERO==1, the bypass is suppressed.
- WbValid <= 1 on the edge where a write commits, else 0. A write discarded by R0_ZERO does not assert it.
- WbCount:
  - Increments by 1 on each committed write.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Discarded writes do not count.
- Back-to-back writes to the same register on consecutive edges: each commits, the last wins, and the counter increments each time.
- There is no write-enable handshake and no backpressure; the block accepts one write per cycle unconditionally.
- All arithmetic is unsigned. Data passes through unmodified, with no truncation because widths match.

Test Plan:
- Reset check: rst=0 with random inputs -> ReadData1/2=0 for every address, WbCount=0, WbValid=0. Assert rst=0 asynchronously between edges after writes -> all registers read 0 immediately.
- Basic write: RegWrite=1, Reg=3, ALUResult=8'hA5 for one edge, then RegWrite=0, ReadReg1=3 -> ReadData1=8'hA5, WbValid=1 for exactly one cycle, WbCount=1.
- Bypass: regs[5]=8'h11; drive RegWrite=1, Reg=5, ALUResult=8'h7E with ReadReg1=ReadReg2=5 before the edge -> both ports read 8'h7E in the same cycle and after the edge. With RegWrite=0 and the same inputs -> ports read 8'h11.
- R0_ZERO=1: write Reg=0, ALUResult=8'hFF -> ReadData1 at address 0 stays 0 before and after the edge, WbCount unchanged, WbValid=0. With R0_ZERO=0 the same stimulus reads 8'hFF.
- Back-to-back: writes to reg 2 of 8'h01, 8'h02, 8'h03 on consecutive edges -> reg 2 reads 8'h03, WbCount increases by 3, WbValid stays high for 3 cycles.
- Saturation: CNT_W=4, 20 committed writes -> WbCount stops at 15 and stays there; a further write leaves it at 15.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-stage register file: commits EX/WB results, serves two bypassed
// read ports to ID, and counts retired writes with saturation.
module wb_regfile #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned R0_ZERO = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EX_WB_RegWrite,
   input  logic [ADDR_W-1:0] EX_WB_Reg,
   input  logic [DATA_W-1:0] EX_WB_ALUResult,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [CNT_W-1:0]  WbCount,
   output logic              WbValid
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [CNT_W-1:0]  wb_count_q, wb_count_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wr_en;
   logic              r0_hit;
   logic              commit;

   // Bypass is gated by rst so ports read zero for the whole reset window.
   always_comb begin
      wr_en  = rst && EX_WB_RegWrite;
      r0_hit = (R0_ZERO != 0) && (EX_WB_Reg == '0);
      commit = wr_en && !r0_hit;
   end

   always_comb begin
      regs_d     = regs_q;
      wb_count_d = wb_count_q;
      wb_valid_d = commit;
      if (commit) begin
         regs_d[EX_WB_Reg] = EX_WB_ALUResult;
         if (wb_count_q != '1) begin
            wb_count_d = wb_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_count_q <= '0;
         wb_valid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
         wb_valid_q <= wb_valid_d;
      end
   end

   always_comb begin
      ReadData1 = regs_q[ReadReg1];
      if ((R0_ZERO != 0) && (ReadReg1 == '0)) begin
         ReadData1 = '0;
      end else if (wr_en && (EX_WB_Reg == ReadReg1)) begin
         ReadData1 = EX_WB_ALUResult;
      end
   end

   always_comb begin
      ReadData2 = regs_q[ReadReg2];
      if ((R0_ZERO != 0) && (ReadReg2 == '0)) begin
         ReadData2 = '0;
      end else if (wr_en && (EX_WB_Reg == ReadReg2)) begin
         ReadData2 = EX_WB_ALUResult;
      end
   end

   assign WbCount = wb_count_q;
   assign WbValid = wb_valid_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two instances (default, and R0_ZERO=1 with a 4-bit
// counter) share stimulus and are compared against an array-based model.
module tb_wb_regfile;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       we;
   logic [2:0] wreg, rr1, rr2;
   logic [7:0] alu;

   logic [7:0]  a_rd1, a_rd2, b_rd1, b_rd2;
   logic [15:0] a_cnt;
   logic [3:0]  b_cnt;
   logic        a_val, b_val;

   int total = 0;
   int bad   = 0;

   int m_reg [2][8];
   int m_cnt [2];
   int m_val [2];
   int cmax  [2] = '{65535, 15};
   int r0z   [2] = '{0, 1};

   wb_regfile #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst),
      .EX_WB_RegWrite(we), .EX_WB_Reg(wreg), .EX_WB_ALUResult(alu),
      .ReadReg1(rr1), .ReadReg2(rr2),
      .ReadData1(a_rd1), .ReadData2(a_rd2),
      .WbCount(a_cnt), .WbValid(a_val)
   );

   wb_regfile #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .EX_WB_RegWrite(we), .EX_WB_Reg(wreg), .EX_WB_ALUResult(alu),
      .ReadReg1(rr1), .ReadReg2(rr2),
      .ReadData1(b_rd1), .ReadData2(b_rd2),
      .WbCount(b_cnt), .WbValid(b_val)
   );

   function automatic int exp_rd(int k, int a);
      if (rst !== 1'b1) return 0;
      if (r0z[k] == 1 && a == 0) return 0;
      if (we && int'(wreg) == a) return int'(alu);
      return m_reg[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 8; a++) m_reg[k][a] = 0;
         m_cnt[k] = 0;
         m_val[k] = 0;
      end
   endtask

   task automatic model_edge();
      if (rst === 1'b1) begin
         for (int k = 0; k < 2; k++) begin
            bit c;
            c = we && !(r0z[k] == 1 && wreg == 3'd0);
            m_val[k] = c ? 1 : 0;
            if (c) begin
               m_reg[k][int'(wreg)] = int'(alu);
               if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a_rd1"}, 32'(a_rd1), exp_rd(0, int'(rr1)));
      chk({tag, ".a_rd2"}, 32'(a_rd2), exp_rd(0, int'(rr2)));
      chk({tag, ".b_rd1"}, 32'(b_rd1), exp_rd(1, int'(rr1)));
      chk({tag, ".b_rd2"}, 32'(b_rd2), exp_rd(1, int'(rr2)));
      chk({tag, ".a_cnt"}, 32'(a_cnt), m_cnt[0]);
      chk({tag, ".b_cnt"}, 32'(b_cnt), m_cnt[1]);
      chk({tag, ".a_val"}, 32'(a_val), m_val[0]);
      chk({tag, ".b_val"}, 32'(b_val), m_val[1]);
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; wreg = '0; alu = '0; rr1 = '0; rr2 = '0;
      model_reset();

      // Held in reset with random traffic: everything reads zero.
      for (int i = 0; i < 8; i++) begin
         we = 1'($urandom); wreg = 3'($urandom); alu = 8'($urandom);
         rr1 = 3'(i); rr2 = 3'(7 - i);
         tick();
         check_all("reset");
      end

      rst = 1'b1; we = 1'b0;
      #1 check_all("release");

      // Basic write, WbValid pulses exactly one cycle.
      we = 1'b1; wreg = 3'd3; alu = 8'hA5; rr1 = 3'd3; rr2 = 3'd0;
      tick();
      we = 1'b0;
      check_all("basic1");
      chk("basic_data", 32'(a_rd1), 32'hA5);
      tick();
      check_all("basic2");

      // Bypass on both ports addressing the same register.
      we = 1'b1; wreg = 3'd5; alu = 8'h11;
      tick();
      we = 1'b0; alu = 8'h7E; rr1 = 3'd5; rr2 = 3'd5;
      #1 check_all("byp_off");
      chk("byp_off_data", 32'(a_rd2), 32'h11);
      we = 1'b1;
      #1 check_all("byp_on");
      chk("byp_on_data", 32'(b_rd1), 32'h7E);
      tick();
      check_all("byp_after");
      we = 1'b0;
      #1 check_all("byp_hold");

      // Register 0 write: kept by dut_a, discarded by dut_b.
      we = 1'b1; wreg = 3'd0; alu = 8'hFF; rr1 = 3'd0; rr2 = 3'd0;
      #1 check_all("r0_pre");
      tick();
      we = 1'b0;
      check_all("r0_post");
      chk("r0_a_data", 32'(a_rd1), 32'hFF);
      chk("r0_b_data", 32'(b_rd1), 32'h0);

      // Back-to-back writes to the same register.
      for (int v = 1; v <= 3; v++) begin
         we = 1'b1; wreg = 3'd2; alu = 8'(v); rr1 = 3'd2; rr2 = 3'd3;
         tick();
         check_all("b2b");
      end
      we = 1'b0;
      tick();
      check_all("b2b_end");

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom_range(0, 1)); wreg = 3'($urandom); alu = 8'($urandom);
         rr1 = 3'($urandom); rr2 = 3'($urandom);
         #1 check_all("rand_pre");
         tick();
         check_all("rand_post");
      end

      // Saturation of the 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         we = 1'b1; wreg = 3'd1; alu = 8'($urandom); rr1 = 3'd1; rr2 = 3'd7;
         tick();
         check_all("sat");
      end
      chk("sat_b_cnt", 32'(b_cnt), 32'd15);
      tick();
      check_all("sat_more");
      chk("sat_b_cnt2", 32'(b_cnt), 32'd15);

      // Asynchronous reset between edges with a write pending.
      we = 1'b1; wreg = 3'd4; alu = 8'h3C; rr1 = 3'd1; rr2 = 3'd4;
      #2 rst = 1'b0;
      model_reset();
      #1 check_all("async");
      for (int i = 0; i < 8; i++) begin
         rr1 = 3'(i);
         #0 chk("async_rd", 32'(a_rd1), 32'h0);
      end
      tick();
      check_all("rst_edge");

      rst = 1'b1; we = 1'b1; wreg = 3'd6; alu = 8'h5A; rr1 = 3'd6; rr2 = 3'd4;
      tick();
      we = 1'b0;
      check_all("post_rst");
      chk("post_rst_data", 32'(b_rd1), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
